// File: rtl/instr_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared types and default constants for the fetch stage of the 9-bit core.
//   fetch_state_t   : IDLE / ARMED / RUN / HALT sequencing of the fetch unit
//   HALT_INSTR_DEF  : instruction encoding that stops fetch
//   OFS_W_DEF       : width of the signed PC-relative branch offset
// ----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [8:0] HALT_INSTR_DEF = 9'h1FF;
    localparam int         OFS_W_DEF      = 6;

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the control, ROM and status signals of the fetch unit.
//   master : driver side (control + ROM data out, status in)
//   slave  : fetch unit side
// Signals:
//   Start, Start_Addr   : restart request and program entry address
//   Branch, Zero        : branch decode and ALU zero flag for current instr
//   InstrIn             : word fetched at PC (combinational ROM read)
//   PC                  : address of the current instruction
//   Running, Done       : RUN / HALT status
//   InstrCount          : instructions retired since last Start
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
);
    logic               Start;
    logic [PC_W-1:0]    Start_Addr;
    logic               Branch;
    logic               Zero;
    logic [INSTR_W-1:0] InstrIn;
    logic [PC_W-1:0]    PC;
    logic               Running;
    logic               Done;
    logic [CNT_W-1:0]   InstrCount;

    modport master (
        output Start, Start_Addr, Branch, Zero, InstrIn,
        input  PC, Running, Done, InstrCount
    );

    modport slave (
        input  Start, Start_Addr, Branch, Zero, InstrIn,
        output PC, Running, Done, InstrCount
    );
endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the retired-instruction count.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (count -> 0)
//   clr     : synchronous clear, wins over inc
//   inc     : add one, sticks at all-ones instead of wrapping
//   count   : registered count value
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule : sat_counter

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage of the 9-bit-instruction core. Owns the PC, loads Start_Addr,
// steps sequentially, takes PC-relative branches (Branch & Zero), stops on the
// halt encoding and counts retired (non-halt) instructions.
//   CLK    : clock, rising edge
//   RST_n  : asynchronous active-low reset
//   bus    : instr_fetch_unit_if.slave (Start, Start_Addr, Branch, Zero,
//            InstrIn in; PC, Running, Done, InstrCount out, all registered)
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                 PC_W       = 8,
    parameter int                 INSTR_W    = 9,
    parameter int                 OFS_W      = OFS_W_DEF,
    parameter int                 CNT_W      = 16,
    parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic                CLK,
    input  logic                RST_n,
    instr_fetch_unit_if.slave   bus
);
    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            cnt_clr;
    logic            cnt_inc;
    logic [PC_W-1:0] branch_ofs;

    // Sign-extended branch offset from the low bits of the fetched word.
    assign branch_ofs = {{(PC_W-OFS_W){bus.InstrIn[OFS_W-1]}}, bus.InstrIn[OFS_W-1:0]};

    // Branch/Zero/InstrIn are only looked at inside the RUN arm, so unknown
    // values on them outside RUN cannot disturb the state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        running_d = running_q;
        done_d    = done_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        if (bus.Start) begin
            state_d   = ARMED;
            pc_d      = bus.Start_Addr;
            running_d = 1'b0;
            done_d    = 1'b0;
            cnt_clr   = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                ARMED: begin
                    // PC already holds Start_Addr, so the first fetch is the entry.
                    state_d   = RUN;
                    running_d = 1'b1;
                end
                RUN: begin
                    if (bus.InstrIn == HALT_INSTR) begin
                        state_d   = HALT;
                        done_d    = 1'b1;
                        running_d = 1'b0;
                    end else begin
                        cnt_inc = 1'b1;
                        if (bus.Branch && bus.Zero) begin
                            pc_d = pc_q + branch_ofs;
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                end
                HALT: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_instr_cnt (
        .clk   (CLK),
        .rst_n (RST_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (bus.InstrCount)
    );

    assign bus.PC      = pc_q;
    assign bus.Running = running_q;
    assign bus.Done    = done_q;
endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed, table-driven bench for instr_fetch_unit. A 16-bit-count instance
// carries the main vectors; a 4-bit-count instance exercises saturation.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic CLK;
    logic RST_n;

    instr_fetch_unit_if #(.PC_W(8), .INSTR_W(9), .CNT_W(16)) bus ();
    instr_fetch_unit_if #(.PC_W(8), .INSTR_W(9), .CNT_W(4))  bus4 ();

    instr_fetch_unit #(.CNT_W(16)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus.slave)
    );

    instr_fetch_unit #(.CNT_W(4)) dut4 (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus4.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        start;
        logic [7:0]  addr;
        logic        br;
        logic        z;
        logic [8:0]  instr;
        logic [7:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [7:0] a, input logic b,
                                input logic zz, input logic [8:0] ins, input logic [7:0] p,
                                input logic r, input logic d, input logic [15:0] c);
        vec_t v;
        v.start = st; v.addr = a; v.br = b; v.z = zz; v.instr = ins;
        v.pc = p; v.run = r; v.done = d; v.cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic [7:0] a, input logic b,
                         input logic zz, input logic [8:0] ins);
        bus.Start  = st;  bus.Start_Addr  = a; bus.Branch  = b; bus.Zero  = zz; bus.InstrIn  = ins;
        bus4.Start = st;  bus4.Start_Addr = a; bus4.Branch = b; bus4.Zero = zz; bus4.InstrIn = ins;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [7:0] p, input logic r,
                              input logic d, input logic [15:0] c);
        check({tag, ".PC"},         32'(bus.PC),         32'(p));
        check({tag, ".Running"},    32'(bus.Running),    32'(r));
        check({tag, ".Done"},       32'(bus.Done),       32'(d));
        check({tag, ".InstrCount"}, 32'(bus.InstrCount), 32'(c));
    endtask

    initial begin
        // ---------------- vector table (one row = one clock edge) ----------
        // Entry at 0x10, held 2 cycles, then 3 plain instructions.
        vecs.push_back(mk(1, 8'h10, 0, 0, 9'h000, 8'h10, 0, 0, 0));
        vecs.push_back(mk(1, 8'h10, 0, 0, 9'h000, 8'h10, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'h10, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'h11, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'h12, 1, 0, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'h13, 1, 0, 3));
        // Taken branch -4 from 0x20.
        vecs.push_back(mk(1, 8'h20, 0, 0, 9'h000, 8'h20, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'h20, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 9'h03C, 8'h1C, 1, 0, 1));
        // Not taken (Zero=0) from 0x20.
        vecs.push_back(mk(1, 8'h20, 0, 0, 9'h000, 8'h20, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'h20, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 9'h03C, 8'h21, 1, 0, 1));
        // +31 from 0xF0 wraps to 0x0F, then offset 0 re-executes 0x0F.
        vecs.push_back(mk(1, 8'hF0, 0, 0, 9'h000, 8'hF0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'hF0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 9'h01F, 8'h0F, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 9'h000, 8'h0F, 1, 0, 2));
        // PC wrap FE, FF, 00 then halt (with Branch&Zero set: halt wins).
        vecs.push_back(mk(1, 8'hFE, 0, 0, 9'h000, 8'hFE, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'hFE, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'hFF, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'h00, 1, 0, 2));
        vecs.push_back(mk(0, 8'h00, 1, 1, 9'h1FF, 8'h00, 0, 1, 2));
        // HALT ignores Branch/Zero/InstrIn for 5 cycles.
        vecs.push_back(mk(0, 8'h00, 1, 1, 9'h03C, 8'h00, 0, 1, 2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 9'h000, 8'h00, 0, 1, 2));
        vecs.push_back(mk(0, 8'h00, 1, 0, 9'h001, 8'h00, 0, 1, 2));
        vecs.push_back(mk(0, 8'h00, 1, 1, 9'h1FF, 8'h00, 0, 1, 2));
        vecs.push_back(mk(0, 8'h00, 0, 1, 9'h0AA, 8'h00, 0, 1, 2));
        // Start from HALT clears Done and rearms at 0x30.
        vecs.push_back(mk(1, 8'h30, 0, 0, 9'h000, 8'h30, 0, 0, 0));

        // ---------------- 1: reset with random inputs ----------------------
        RST_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 9'($urandom));
            step();
            check_main("reset", 8'h00, 0, 0, 16'h0);
            check("reset.state", 32'(dut.state_q), 32'(IDLE));
        end
        @(negedge CLK);
        drive(0, 8'h00, 0, 0, 9'h000);
        RST_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'($urandom), 1'($urandom), 1'($urandom), 9'($urandom));
            step();
            check_main("idle_hold", 8'h00, 0, 0, 16'h0);
            check("idle_hold.state", 32'(dut.state_q), 32'(IDLE));
        end

        // ---------------- 2-4: table-driven vectors ------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].addr, vecs[i].br, vecs[i].z, vecs[i].instr);
            step();
            check_main($sformatf("vec%0d", i), vecs[i].pc, vecs[i].run, vecs[i].done, vecs[i].cnt);
        end

        // ---------------- 5: async reset mid-RUN ---------------------------
        drive(0, 8'h00, 0, 0, 9'h000);
        step();
        step();
        step();
        check_main("pre_rst", 8'h32, 1, 0, 16'd2);
        #3;
        RST_n = 1'b0;
        #1;
        check_main("async_rst", 8'h00, 0, 0, 16'h0);
        check("async_rst.cnt4", 32'(bus4.InstrCount), 32'h0);
        @(negedge CLK);
        RST_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_main("post_rst_idle", 8'h00, 0, 0, 16'h0);
        end
        drive(1, 8'h40, 0, 0, 9'h000);
        step();
        check_main("restart_armed", 8'h40, 0, 0, 16'h0);
        drive(0, 8'h00, 0, 0, 9'h000);
        step();
        check_main("restart_run", 8'h40, 1, 0, 16'h0);
        step();
        check_main("restart_step", 8'h41, 1, 0, 16'd1);

        // ---------------- 6: saturation on the 4-bit counter ---------------
        drive(1, 8'h00, 0, 0, 9'h000);
        step();
        drive(0, 8'h00, 0, 0, 9'h000);
        step();
        check("sat.run", 32'(bus4.Running), 32'h1);
        for (int i = 1; i <= 17; i++) begin
            step();
            check($sformatf("sat.cnt%0d", i), 32'(bus4.InstrCount), (i > 15) ? 32'hF : 32'(i));
            check($sformatf("sat.pc%0d", i), 32'(bus4.PC), 32'(i));
        end
        check("wide.cnt17", 32'(bus.InstrCount), 32'd17);
        drive(1, 8'h77, 0, 0, 9'h000);
        step();
        check("sat.restart_cnt", 32'(bus4.InstrCount), 32'h0);
        check("sat.restart_pc", 32'(bus4.PC), 32'h77);
        check("sat.restart_run", 32'(bus4.Running), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_instr_fetch_unit
